uart_tx_arbiter: RTL and testbench

Shares one uart_tx byte transmitter among N_CLIENTS byte-stream requesters using round-robin arbitration with optional packet locking. It accepts one byte per grant over a valid/ready handshake, issues a single-cycle tx_start with registered tx_data, and tracks tx_busy until the UART returns to idle. It sits between client logic (e.g. echo/mirror paths, status reporters) and uart_tx.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Client byte-stream and uart_tx handshake bundle for uart_tx_arbiter.
// master = arbiter side, slave = clients plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int N_CLIENTS = 4
);
  logic [N_CLIENTS-1:0]   cl_valid;
  logic [8*N_CLIENTS-1:0] cl_data;
  logic [N_CLIENTS-1:0]   cl_last;
  logic [N_CLIENTS-1:0]   cl_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_busy;

  modport master (
    input  cl_valid, cl_data, cl_last, tx_busy,
    output cl_ready, tx_start, tx_data
  );

  modport slave (
    output cl_valid, cl_data, cl_last, tx_busy,
    input  cl_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_CLIENTS byte streams,
// with optional packet locking and a tx_busy rise timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | wait for an eligible request while the UART is idle; grant
// START     | one-cycle tx_start pulse with the registered byte
// WAIT_BUSY | wait for tx_busy to rise; timeout down-counter runs
// WAIT_DONE | wait for tx_busy to fall
module uart_tx_arbiter #(
  parameter int N_CLIENTS    = 4,
  parameter bit LOCK_PACKETS = 1'b1,
  parameter int BUSY_TIMEOUT = 15,
  localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_arbiter_if.master     bus,
  output logic [CW-1:0]         grant_id,
  output logic                  locked,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        rr;
  logic [CW-1:0]        win;
  logic                 found;
  logic [N_CLIENTS-1:0] elig;
  logic                 grant;
  logic                 timeout_hit;
  logic [7:0]           cnt;
  logic [7:0]           tx_data_q;

  // While locked only the holder of the grant is eligible.
  always_comb begin : arb_search
    int idx;
    elig = bus.cl_valid;
    if (locked) elig = bus.cl_valid & (N_CLIENTS'(1) << grant_id);
    win   = rr;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      idx = (int'(rr) + i) % N_CLIENTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  assign grant       = (state == IDLE) && found && !bus.tx_busy;
  assign timeout_hit = (state == WAIT_BUSY) && !bus.tx_busy && (cnt == 8'd0);
  assign bus.tx_data = tx_data_q;

  always_comb begin
    bus.cl_ready = '0;
    if (grant) bus.cl_ready[win] = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    bus.tx_start = 1'b0;
    case (state)
      IDLE:      if (grant) state_nxt = START;
      START: begin
        bus.tx_start = 1'b1;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy)      state_nxt = WAIT_DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_data_q   <= 8'h00;
      grant_id    <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      rr          <= CW'(N_CLIENTS - 1);
      cnt         <= 8'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        tx_data_q <= bus.cl_data[{win, 3'b000} +: 8];
        grant_id  <= win;
        if (LOCK_PACKETS) begin
          locked <= ~bus.cl_last[win];
          if (bus.cl_last[win]) rr <= win;
        end else begin
          locked <= 1'b0;
          rr     <= win;
        end
      end
      // Down-counter loaded in START; terminal count 0 ends the wait.
      if (state == START)
        cnt <= 8'(BUSY_TIMEOUT - 1);
      else if ((state == WAIT_BUSY) && !bus.tx_busy && (cnt != 8'd0))
        cnt <= cnt - 8'd1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed client streams, a simple
// uart_tx busy model, and a negedge monitor comparing each tx_start.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
    logic       lk;
  } ex_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       locked, err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_CLIENTS(N)) bus ();

  uart_tx_arbiter #(.N_CLIENTS(N), .LOCK_PACKETS(1'b1), .BUSY_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .locked(locked), .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_pass = 0;
  ex_t ex_q[$];

  logic [8:0] cmem [N][32];
  int head [N];
  int tail [N];
  logic [N-1:0] acc = '0;
  logic [N-1:0] hold = '0;
  bit  uart_en = 1'b1;
  bit  pend = 1'b0;
  int  busy_cnt = 0;
  int  busy_len = 6;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic push(int c, logic [7:0] d, logic last, logic [7:0] ed, logic lk);
    cmem[c][tail[c]] = {last, d};
    tail[c]++;
    ex_q.push_back('{gid: 2'(c), data: ed, lk: lk});
  endtask

  task automatic wait_drain(string nm);
    int k = 0;
    int quiet = 0;
    while (quiet < 3 && k < 3000) begin
      @(negedge clk);
      k++;
      if (ex_q.size() == 0 && !bus.tx_busy && !bus.tx_start) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_chk++;
      $display("FAIL %s_drain: %0d entries left after %0d cycles", nm, ex_q.size(), k);
    end
  endtask

  // Clients and uart_tx model update after the edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) head[i]++;
      bus.cl_valid[i] = (head[i] < tail[i]) && !hold[i];
      bus.cl_data[8*i +: 8] = (head[i] < tail[i]) ? cmem[i][head[i]][7:0] : 8'h00;
      bus.cl_last[i] = (head[i] < tail[i]) ? cmem[i][head[i]][8] : 1'b0;
    end
    if (uart_en) begin
      if (pend) begin
        busy_cnt = busy_len;
        pend = 1'b0;
      end else if (busy_cnt > 0) busy_cnt--;
    end else begin
      busy_cnt = 0;
      pend = 1'b0;
    end
    bus.tx_busy = (busy_cnt > 0);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    ex_t e;
    acc = bus.cl_valid & bus.cl_ready;
    if (bus.tx_start && uart_en) pend = 1'b1;
    if (rst_n) begin
      if (bus.cl_ready != '0) begin
        chk("ready_while_busy", 32'(bus.tx_busy), 32'd0);
        chk("ready_onehot", 32'(bus.cl_ready),
            (ex_q.size() > 0) ? (32'd1 << ex_q[0].gid) : 32'd0);
      end
      if (bus.tx_start) begin
        chk("start_while_busy", 32'(bus.tx_busy), 32'd0);
        if (ex_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_start: got data %0h expected no start", bus.tx_data);
        end else begin
          e = ex_q.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(e.data));
          chk("grant_id", 32'(grant_id), 32'(e.gid));
          chk("locked", 32'(locked), 32'(e.lk));
        end
      end
    end
  end

  initial begin
    int k, n, rc;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    bus.cl_valid = '0;
    bus.cl_data  = '0;
    bus.cl_last  = '0;
    bus.tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.cl_ready), 32'd0);
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // single byte
    push(1, 8'h41, 1'b1, 8'h41, 1'b0);
    wait_drain("single");

    // round-robin, rr=1 after previous grant
    push(0, 8'h10, 1'b1, 8'h12, 1'b0);
    push(1, 8'h11, 1'b1, 8'h12, 1'b0);
    push(2, 8'h12, 1'b1, 8'h12, 1'b0);
    push(3, 8'h13, 1'b1, 8'h12, 1'b0);
    push(0, 8'h10, 1'b1, 8'h12, 1'b0);
    ex_q.delete();
    ex_q.push_back('{gid: 2'd2, data: 8'h12, lk: 1'b0});
    ex_q.push_back('{gid: 2'd3, data: 8'h13, lk: 1'b0});
    ex_q.push_back('{gid: 2'd0, data: 8'h10, lk: 1'b0});
    ex_q.push_back('{gid: 2'd1, data: 8'h11, lk: 1'b0});
    ex_q.push_back('{gid: 2'd0, data: 8'h10, lk: 1'b0});
    wait_drain("rr");

    // packet lock: client 2 holds the grant over a valid client 0
    push(2, 8'hA0, 1'b0, 8'hA0, 1'b1);
    push(2, 8'hA1, 1'b0, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1, 8'hA2, 1'b0);
    push(0, 8'h55, 1'b1, 8'h55, 1'b0);
    wait_drain("lock");

    // stalled lock
    push(3, 8'h30, 1'b0, 8'h30, 1'b1);
    wait_drain("stall_a");
    hold[3] = 1'b1;
    push(3, 8'h3F, 1'b1, 8'h3F, 1'b0);
    push(1, 8'h71, 1'b1, 8'h71, 1'b0);
    rc = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.cl_ready[1]) rc++;
    end
    chk("stall_no_ready", 32'(rc), 32'd0);
    chk("stall_locked", 32'(locked), 32'd1);
    hold[3] = 1'b0;
    wait_drain("stall_b");

    // timeout with a dead transmitter
    uart_en = 1'b0;
    push(2, 8'h5A, 1'b1, 8'h5A, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.tx_start && k < 100);
    chk("timeout_start_seen", 32'(bus.tx_start), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 40);
    chk("timeout_cycles", 32'(n), 32'd16);
    uart_en = 1'b1;
    push(0, 8'h66, 1'b1, 8'h66, 1'b0);
    wait_drain("timeout");
    chk("err_sticky", 32'(err_timeout), 32'd1);

    // reset mid-transfer
    busy_len = 30;
    push(0, 8'hC0, 1'b1, 8'hC0, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (ex_q.size() != 0 && k < 100);
    repeat (3) @(negedge clk);
    cmem[0][tail[0]] = {1'b1, 8'h90}; tail[0]++;
    cmem[1][tail[1]] = {1'b1, 8'h91}; tail[1]++;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.cl_ready), 32'd0);
    chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
    chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    chk("mid_rst_err", 32'(err_timeout), 32'd0);
    chk("mid_rst_busy_held", 32'(bus.tx_busy), 32'd1);
    ex_q.push_back('{gid: 2'd0, data: 8'h90, lk: 1'b0});
    ex_q.push_back('{gid: 2'd1, data: 8'h91, lk: 1'b0});
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rc = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (bus.cl_ready != '0 && bus.tx_busy) rc++;
    end while (bus.tx_busy && k < 100);
    chk("post_rst_no_ready", 32'(rc), 32'd0);
    wait_drain("reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
